// File: rtl/core_sequencer.sv
// Drives core.inst through the weight-stationary convolution schedule for one tile.
// Optional macro SEQ_PERF_CNT_EN builds the busy-cycle counter behind o_cycle_cnt.
module core_sequencer #(
  parameter int unsigned ROW    = 8,
  parameter int unsigned COL    = 8,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned IW     = 6,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned W_BASE = 1024,
  parameter int unsigned DRAIN  = 10,
  localparam int unsigned LEN_KIJ  = KSIZE * KSIZE,
  localparam int unsigned LEN_NIJ  = IW * IW,
  localparam int unsigned OW       = IW - KSIZE + 1,
  localparam int unsigned LEN_ONIJ = OW * OW,
  localparam int unsigned INST_W   = 12 + 2 * ADDR_W,
  localparam int unsigned IDX_W    = $clog2(LEN_ONIJ)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_ofifo_valid,
  output logic [INST_W-1:0] o_inst,
  output logic              o_core_clr,
  output logic              o_out_valid,
  output logic [IDX_W-1:0]  o_out_idx,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_cycle_cnt
);

  localparam int unsigned T_W   = $clog2(LEN_NIJ + COL + DRAIN + LEN_KIJ + 2);
  localparam int unsigned KIJ_W = $clog2(LEN_KIJ + 1);

  localparam int unsigned B_LOAD = 0;
  localparam int unsigned B_EXEC = 1;
  localparam int unsigned B_L0WR = 2;
  localparam int unsigned B_L0RD = 3;
  localparam int unsigned B_OFRD = 6;
  localparam int unsigned B_AX   = 7;
  localparam int unsigned B_WENX = 7 + ADDR_W;
  localparam int unsigned B_CENX = 8 + ADDR_W;
  localparam int unsigned B_AP   = 9 + ADDR_W;
  localparam int unsigned B_WENP = 9 + 2 * ADDR_W;
  localparam int unsigned B_CENP = 10 + 2 * ADDR_W;
  localparam int unsigned B_ACC  = 11 + 2 * ADDR_W;

  localparam logic [INST_W-1:0] IDLE_INST = (INST_W'(1) << B_CENP) | (INST_W'(1) << B_WENP) |
                                            (INST_W'(1) << B_CENX) | (INST_W'(1) << B_WENX);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CLR     = 4'd1;
  localparam logic [3:0] S_W_L0    = 4'd2;
  localparam logic [3:0] S_W_LOAD  = 4'd3;
  localparam logic [3:0] S_W_DRAIN = 4'd4;
  localparam logic [3:0] S_X_L0    = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_OFIFO   = 4'd7;
  localparam logic [3:0] S_ACC_CLR = 4'd8;
  localparam logic [3:0] S_ACC     = 4'd9;
  localparam logic [3:0] S_ACC_OUT = 4'd10;
  localparam logic [3:0] S_DONE    = 4'd11;

  // Psum region must sit below the weights, and the weights must fit the address space.
  if (ROW == 0 || COL == 0 || DRAIN == 0 || KSIZE == 0 || IW <= KSIZE) begin : g_bad_geom
    $error("core_sequencer: unsupported array or tile geometry");
  end
  if (LEN_KIJ * LEN_NIJ > W_BASE) begin : g_bad_psum
    $error("core_sequencer: psum region overlaps weight region");
  end
  if (64'(W_BASE) + 64'(LEN_KIJ * COL) > (64'd1 << ADDR_W)) begin : g_bad_wgt
    $error("core_sequencer: weight region exceeds address space");
  end

  logic [3:0]        r_state, w_nxt_state;
  logic [T_W-1:0]    r_t, w_nxt_t;
  logic [KIJ_W-1:0]  r_kij, w_nxt_kij;
  logic [IDX_W-1:0]  r_o, w_nxt_o;
  logic [INST_W-1:0] r_inst, w_inst;
  logic [IDX_W-1:0]  r_out_idx;
  logic              r_core_clr, w_core_clr;
  logic              r_out_valid, w_out_valid;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic [ADDR_W-1:0] w_x_addr, w_p_addr;

  // Memory addresses for the current state and step counter.
  always_comb begin
    w_x_addr = ADDR_W'(32'(r_t));
    if (r_state == S_W_L0) w_x_addr = ADDR_W'(W_BASE + 32'(r_kij) * COL + 32'(r_t));
    w_p_addr = ADDR_W'(32'(r_kij) * LEN_NIJ + 32'(r_t));
    if (r_state == S_ACC)
      w_p_addr = ADDR_W'(32'(r_t) * LEN_NIJ + (32'(r_o) / OW + 32'(r_t) / KSIZE) * IW +
                         32'(r_o) % OW + 32'(r_t) % KSIZE);
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_t     = r_t + T_W'(1);
    w_nxt_kij   = r_kij;
    w_nxt_o     = r_o;
    w_inst      = IDLE_INST;
    w_core_clr  = 1'b0;
    w_out_valid = 1'b0;
    w_done      = 1'b0;
    w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    case (r_state)
      S_IDLE: begin
        w_nxt_t = '0;
        if (i_start) begin
          w_nxt_state = S_CLR;
          w_nxt_kij   = '0;
          w_nxt_o     = '0;
        end
      end
      S_CLR: begin
        w_core_clr  = 1'b1;
        w_nxt_state = S_W_L0;
        w_nxt_t     = '0;
      end
      S_W_L0: begin
        if (r_t < T_W'(COL)) begin
          w_inst[B_CENX]          = 1'b0;
          w_inst[B_AX +: ADDR_W]  = w_x_addr;
        end
        w_inst[B_L0WR] = (r_t != '0);
        if (r_t == T_W'(COL)) begin
          w_nxt_state = S_W_LOAD;
          w_nxt_t     = '0;
        end
      end
      S_W_LOAD: begin
        w_inst[B_LOAD] = 1'b1;
        w_inst[B_L0RD] = 1'b1;
        if (r_t == T_W'(COL - 1)) begin
          w_nxt_state = S_W_DRAIN;
          w_nxt_t     = '0;
        end
      end
      S_W_DRAIN: begin
        if (r_t == T_W'(DRAIN - 1)) begin
          w_nxt_state = S_X_L0;
          w_nxt_t     = '0;
        end
      end
      S_X_L0: begin
        if (r_t < T_W'(LEN_NIJ)) begin
          w_inst[B_CENX]         = 1'b0;
          w_inst[B_AX +: ADDR_W] = w_x_addr;
        end
        w_inst[B_L0WR] = (r_t != '0);
        if (r_t == T_W'(LEN_NIJ)) begin
          w_nxt_state = S_EXEC;
          w_nxt_t     = '0;
        end
      end
      S_EXEC: begin
        w_inst[B_EXEC] = 1'b1;
        w_inst[B_L0RD] = 1'b1;
        if (r_t == T_W'(LEN_NIJ - 1)) begin
          w_nxt_state = S_OFIFO;
          w_nxt_t     = '0;
        end
      end
      S_OFIFO: begin
        // r_t counts psum rows written; it only advances on a valid OFIFO head.
        w_nxt_t = r_t;
        if (i_ofifo_valid) begin
          w_inst[B_OFRD]         = 1'b1;
          w_inst[B_CENP]         = 1'b0;
          w_inst[B_WENP]         = 1'b0;
          w_inst[B_AP +: ADDR_W] = w_p_addr;
          w_nxt_t                = r_t + T_W'(1);
          if (r_t == T_W'(LEN_NIJ - 1)) begin
            w_nxt_t = '0;
            if (r_kij == KIJ_W'(LEN_KIJ - 1)) begin
              w_nxt_state = S_ACC_CLR;
            end else begin
              w_nxt_state = S_CLR;
              w_nxt_kij   = r_kij + KIJ_W'(1);
            end
          end
        end
      end
      S_ACC_CLR: begin
        w_core_clr  = 1'b1;
        w_nxt_state = S_ACC;
        w_nxt_t     = '0;
      end
      S_ACC: begin
        if (r_t < T_W'(LEN_KIJ)) begin
          w_inst[B_CENP]         = 1'b0;
          w_inst[B_AP +: ADDR_W] = w_p_addr;
        end
        w_inst[B_ACC] = (r_t != '0);
        if (r_t == T_W'(LEN_KIJ)) begin
          w_nxt_state = S_ACC_OUT;
          w_nxt_t     = '0;
        end
      end
      S_ACC_OUT: begin
        w_out_valid = 1'b1;
        w_nxt_t     = '0;
        if (r_o == IDX_W'(LEN_ONIJ - 1)) begin
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_state = S_ACC_CLR;
          w_nxt_o     = r_o + IDX_W'(1);
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_nxt_state = S_IDLE;
        w_nxt_t     = '0;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_t     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_t         <= '0;
      r_kij       <= '0;
      r_o         <= '0;
      r_inst      <= IDLE_INST;
      r_core_clr  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_t         <= w_nxt_t;
      r_kij       <= w_nxt_kij;
      r_o         <= w_nxt_o;
      r_inst      <= w_inst;
      r_core_clr  <= w_core_clr;
      r_out_valid <= w_out_valid;
      r_out_idx   <= r_o;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state == S_IDLE && i_start)) r_cycle_cnt <= '0;
    else if (r_busy)                              r_cycle_cnt <= r_cycle_cnt + 32'd1;
  end

  assign o_cycle_cnt = r_cycle_cnt;
`else
  assign o_cycle_cnt = 32'd0;
`endif

  assign o_inst      = r_inst;
  assign o_core_clr  = r_core_clr;
  assign o_out_valid = r_out_valid;
  assign o_out_idx   = r_out_idx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: reset/start vector table, then full-tile passes
// (steady, toggling and random OFIFO valid) checked against a schedule model.
`timescale 1ns/1ps
module tb_core_sequencer;

  localparam int unsigned COL      = 8;
  localparam int unsigned KSIZE    = 3;
  localparam int unsigned IW       = 6;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned W_BASE   = 1024;
  localparam int unsigned DRAIN    = 10;
  localparam int unsigned LEN_KIJ  = KSIZE * KSIZE;
  localparam int unsigned LEN_NIJ  = IW * IW;
  localparam int unsigned OW       = IW - KSIZE + 1;
  localparam int unsigned LEN_ONIJ = OW * OW;
  localparam int unsigned INST_W   = 12 + 2 * ADDR_W;
  localparam int unsigned IDX_W    = 4;
  // Fixed-length part of one kernel iteration (everything before OFIFO drain).
  localparam int unsigned PRE_OFIFO = 1 + (COL + 1) + COL + DRAIN + (LEN_NIJ + 1) + LEN_NIJ;
  localparam int unsigned ACC_PIX   = 1 + (LEN_KIJ + 1) + 1;

  logic              clk;
  logic              i_reset, i_start, i_ofifo_valid;
  logic [INST_W-1:0] o_inst;
  logic              o_core_clr, o_out_valid, o_busy, o_done;
  logic [IDX_W-1:0]  o_out_idx;
  logic [31:0]       o_cycle_cnt;

  core_sequencer #(.ROW(8), .COL(COL), .KSIZE(KSIZE), .IW(IW), .ADDR_W(ADDR_W),
                   .W_BASE(W_BASE), .DRAIN(DRAIN)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_ofifo_valid(i_ofifo_valid),
    .o_inst(o_inst), .o_core_clr(o_core_clr), .o_out_valid(o_out_valid),
    .o_out_idx(o_out_idx), .o_busy(o_busy), .o_done(o_done), .o_cycle_cnt(o_cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst, start, valid;
    logic [INST_W-1:0] inst;
    logic              clr, ov, busy, done;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       cnt;
  } samp_t;

  typedef struct {
    logic              rst, start;
    logic              exp_busy, exp_clr;
    logic [INST_W-1:0] exp_inst;
  } vec_t;

  samp_t trace[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [INST_W-1:0] idle_inst;

  function automatic logic [INST_W-1:0] mk_inst(input logic cenx, input logic wenx,
      input int unsigned ax, input logic cenp, input logic wenp, input int unsigned ap,
      input logic [6:0] low, input logic acc);
    logic [INST_W-1:0] v;
    v        = '0;
    v[6:0]   = low;
    v[17:7]  = ADDR_W'(ax);
    v[18]    = wenx;
    v[19]    = cenx;
    v[30:20] = ADDR_W'(ap);
    v[31]    = wenp;
    v[32]    = cenp;
    v[33]    = acc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_q(input string name, input int unsigned got[$], input int unsigned exp[$]);
    int m, bad;
    m   = (got.size() < exp.size()) ? got.size() : exp.size();
    bad = -1;
    for (int i = 0; i < m; i++) if (bad < 0 && got[i] != exp[i]) bad = i;
    if (bad < 0 && got.size() != exp.size()) bad = m;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: entry %0d got %0d expected %0d (sizes %0d/%0d)", name, bad,
               (bad < got.size()) ? got[bad] : 0, (bad < exp.size()) ? exp[bad] : 0,
               got.size(), exp.size());
    end
  endtask

  // Apply inputs for one edge, then sample outputs on the following falling edge.
  task automatic cycle(input logic rst, input logic st, input logic v);
    samp_t s;
    i_reset       = rst;
    i_start       = st;
    i_ofifo_valid = v;
    @(posedge clk);
    @(negedge clk);
    s.rst = rst; s.start = st; s.valid = v;
    s.inst = o_inst; s.clr = o_core_clr; s.ov = o_out_valid; s.busy = o_busy;
    s.done = o_done; s.idx = o_out_idx; s.cnt = o_cycle_cnt;
    trace.push_back(s);
  endtask

  function automatic logic vsel(input int mode, input int k);
    if (mode == 1) return (k % 2 == 0);
    if (mode == 2) return ($urandom_range(0, 2) != 0);
    return 1'b1;
  endfunction

  // Model derives the schedule from the tile geometry and the applied valid stream.
  task automatic analyze(input string tag, input int mode);
    int pos, n, busy_n, done_n, done_at, clr_n, run, bad_lat, bad_wr, bad_xw, bad_acc;
    int ld_n, ex_n, acc_n;
    int unsigned exp_busy, exp_done, exp_cnt;
    int unsigned xr_e[$], xr_g[$], pr_e[$], pr_g[$], wi_e[$], wi_g[$], wa_e[$], wa_g[$];
    int unsigned ov_e[$], ov_g[$], run_e[$], run_g[$];
    samp_t s;
    pos = 1;
    for (int k = 0; k < LEN_KIJ; k++) begin
      for (int c = 0; c < COL; c++) xr_e.push_back(W_BASE + k * COL + c);
      for (int a = 0; a < LEN_NIJ; a++) xr_e.push_back(a);
      run_e.push_back(COL);
      run_e.push_back(LEN_NIJ);
      pos += PRE_OFIFO;
      n = 0;
      while (n < LEN_NIJ && pos < trace.size()) begin
        if (trace[pos].valid) begin
          wi_e.push_back(pos);
          wa_e.push_back(k * LEN_NIJ + n);
          n++;
        end
        pos++;
      end
    end
    for (int o = 0; o < LEN_ONIJ; o++) begin
      for (int j = 0; j < LEN_KIJ; j++)
        pr_e.push_back(j * LEN_NIJ + (o / OW + j / KSIZE) * IW + (o % OW + j % KSIZE));
      ov_e.push_back(o);
      pos += ACC_PIX;
    end
    exp_done = pos;
    exp_busy = pos - 1;
`ifdef SEQ_PERF_CNT_EN
    exp_cnt = exp_busy;
`else
    exp_cnt = 0;
`endif
    busy_n = 0; done_n = 0; done_at = -1; clr_n = 0; run = 0; bad_lat = 0; bad_wr = 0;
    bad_xw = 0; bad_acc = 0; ld_n = 0; ex_n = 0; acc_n = 0;
    for (int i = 0; i < trace.size(); i++) begin
      s = trace[i];
      busy_n += int'(s.busy);
      clr_n  += int'(s.clr);
      ld_n   += int'(s.inst[0]);
      ex_n   += int'(s.inst[1]);
      if (s.done) begin done_n++; done_at = i; end
      if (!s.inst[19]) xr_g.push_back(s.inst[17:7]);
      if (!s.inst[18]) bad_xw++;
      if (s.inst[2]) begin
        run++;
        if (i == 0 || trace[i-1].inst[19]) bad_lat++;
      end else if (run != 0) begin
        run_g.push_back(run);
        run = 0;
      end
      if (!s.inst[32] && !s.inst[31]) begin
        wi_g.push_back(i);
        wa_g.push_back(s.inst[30:20]);
        if (!s.inst[6] || !s.valid) bad_wr++;
      end else if (s.inst[6]) bad_wr++;
      if (!s.inst[32] && s.inst[31]) pr_g.push_back(s.inst[30:20]);
      if (s.inst[33]) begin
        acc_n++;
        if (i == 0 || trace[i-1].inst[32]) bad_acc++;
      end
      if (s.ov) ov_g.push_back(s.idx);
    end
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
    if (mode == 0) check({tag, "_latency_1425"}, busy_n, 1425);
    if (mode == 1) check({tag, "_toggle_growth"},
                         (busy_n >= 1425 + 9 * 35 && busy_n <= 1425 + 9 * 36), 1);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_done_cycle"}, done_at, exp_done);
    check({tag, "_clr_pulses"}, clr_n, LEN_KIJ + LEN_ONIJ);
    cmp_q({tag, "_xmem_reads"}, xr_g, xr_e);
    check({tag, "_xmem_writes"}, bad_xw, 0);
    cmp_q({tag, "_l0wr_runs"}, run_g, run_e);
    check({tag, "_l0wr_latency"}, bad_lat, 0);
    cmp_q({tag, "_pmem_wr_cycles"}, wi_g, wi_e);
    cmp_q({tag, "_pmem_wr_addrs"}, wa_g, wa_e);
    check({tag, "_ofifo_rd_pairing"}, bad_wr, 0);
    cmp_q({tag, "_pmem_rd_addrs"}, pr_g, pr_e);
    check({tag, "_acc_cycles"}, acc_n, LEN_KIJ * LEN_ONIJ);
    check({tag, "_acc_latency"}, bad_acc, 0);
    cmp_q({tag, "_out_idx"}, ov_g, ov_e);
    check({tag, "_load_cycles"}, ld_n, LEN_KIJ * COL);
    check({tag, "_exec_cycles"}, ex_n, LEN_KIJ * LEN_NIJ);
    check({tag, "_cycle_cnt"}, trace[$].cnt, exp_cnt);
  endtask

  task automatic run_pass(input int mode, input bit poke, input string tag);
    int  guard;
    bit  seen_done;
    trace.delete();
    cycle(1'b0, 1'b1, vsel(mode, 0));
    guard     = 0;
    seen_done = 1'b0;
    while (!seen_done && guard < 6000) begin
      cycle(1'b0, poke && (guard % 250 == 120), vsel(mode, guard + 1));
      seen_done = trace[$].done;
      guard++;
    end
    check({tag, "_done_reached"}, seen_done, 1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    analyze(tag, mode);
  endtask

  initial begin
    vec_t vecs[11];
    int   ex, guard;
    samp_t s;
    idle_inst     = 34'h1_800C_0000;
    i_reset       = 1'b1;
    i_start       = 1'b0;
    i_ofifo_valid = 1'b1;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, idle_inst};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, idle_inst};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, idle_inst};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, idle_inst};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk_inst(1'b0, 1'b1, 1024, 1'b1, 1'b1, 0, 7'h00, 1'b0)};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, mk_inst(1'b0, 1'b1, 1025, 1'b1, 1'b1, 0, 7'h04, 1'b0)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk_inst(1'b0, 1'b1, 1026, 1'b1, 1'b1, 0, 7'h04, 1'b0)};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, idle_inst};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, idle_inst};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, idle_inst};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, idle_inst};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].rst, vecs[i].start, 1'b1);
      s = trace[$];
      check($sformatf("vec%0d_inst", i), s.inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_busy", i), s.busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_clr", i), s.clr, vecs[i].exp_clr);
      check($sformatf("vec%0d_done", i), s.done, 0);
    end

    run_pass(0, 1'b1, "steady_poked");

    // Reset in the middle of the kij=4 EXEC phase.
    trace.delete();
    cycle(1'b0, 1'b1, 1'b1);
    ex    = 0;
    guard = 0;
    while (ex < 4 * LEN_NIJ + 10 && guard < 3000) begin
      cycle(1'b0, 1'b0, 1'b1);
      ex += int'(trace[$].inst[1]);
      guard++;
    end
    check("rst_exec_reached", ex, 4 * LEN_NIJ + 10);
    cycle(1'b1, 1'b0, 1'b1);
    s = trace[$];
    check("rst_exec_inst", s.inst, idle_inst);
    check("rst_exec_busy", s.busy, 0);
    check("rst_exec_clr", s.clr, 0);
    check("rst_exec_ov", s.ov, 0);
    check("rst_exec_cnt", s.cnt, 0);
    cycle(1'b0, 1'b0, 1'b1);
    check("rst_exec_stays_idle", trace[$].inst, idle_inst);
    check("rst_exec_stays_notbusy", trace[$].busy, 0);
    run_pass(0, 1'b0, "after_rst");

    run_pass(1, 1'b0, "toggle");
    run_pass(2, 1'b1, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Hardware replacement for the bench-driven instruction stream of `core`. It runs the full weight-stationary convolution schedule for one input/output tile from a single `start` pulse. Per kernel position it loads weights to L0 and then to the PEs, streams activations, executes, and drains the OFIFO into psum memory. It then issues the accumulation read sequence to the SFP. It sits between the host/top level and `core`, driving `core.inst` and the core's clear.

## Interface
- `row`, 8, PE rows (activation lanes)
- `col`, 8, PE columns; weight words per kernel position
- `ksize`, 3, kernel side; `len_kij = ksize*ksize`
- `iw`, 6, input side; `len_nij = iw*iw`, `ow = iw-ksize+1`, `len_onij = ow*ow` (derived localparams)
- `addr_w`, 11, xmem/pmem address width; instruction width `12+2*addr_w`
- `w_base`, 1024, xmem base address of weight region
- `drain`, 10, idle cycles after kernel load
- `clk  in  1  clock; all state changes on rising edge`
- `reset  in  1  synchronous, active-high; returns to IDLE`
- `start  in  1  one-cycle request, accepted only in IDLE`
- `ofifo_valid  in  1  OFIFO head holds a valid psum row`
- `inst  out  12+2*addr_w  registered core instruction: [top]=acc, CEN_pmem, WEN_pmem, A_pmem, CEN_xmem, WEN_xmem, A_xmem, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load (bit 0)`
- `core_clr  out  1  one-cycle clear of core PE/SFP state`
- `out_valid  out  1  sfp_out holds finished output pixel`
- `out_idx  out  $clog2(len_onij)  index of pixel flagged by out_valid`
- `busy  out  1  high in every state except IDLE and DONE`
- `done  out  1  one-cycle completion pulse`
- `cycle_cnt  out  32  performance counter (see Configuration)`

## Operation
- Idle instruction: CEN/WEN of both memories = 1, all other fields 0. For `addr_w=11` this is 0x1_800C_0000.
- States: IDLE, CLR, W_L0, W_LOAD, W_DRAIN, X_L0, EXEC, OFIFO, ACC_CLR, ACC, ACC_OUT, DONE. Counter `t` restarts at 0 on every state entry.
- IDLE: on `start`, set kij=0 and go to CLR.
- CLR (1 cycle): `core_clr=1`.
- W_L0 (col+1 cycles): for t<col, xmem read (CEN=0, WEN=1) at `w_base+kij*col+t`. `l0_wr=1` for t≥1, because of the 1-cycle SRAM latency.
- W_LOAD (col cycles): `load=1`, `l0_rd=1`.
- W_DRAIN (`drain` cycles): idle instruction.
- X_L0 (len_nij+1 cycles): xmem read at address t for t<len_nij; `l0_wr=1` for t≥1.
- EXEC (len_nij cycles): `execute=1`, `l0_rd=1`.
- OFIFO: each cycle with `ofifo_valid=1`, assert `ofifo_rd=1` together with a pmem write (CEN=0, WEN=0) at `kij*len_nij+n`, then n++. The OFIFO head is combinational, so data is written in the same cycle. Exit after len_nij writes; go to CLR with kij+1, or to ACC_CLR if kij=len_kij-1.
- ACC_CLR (1 cycle): `core_clr=1`.
- ACC (len_kij+1 cycles): for j<len_kij, pmem read at `j*len_nij+(oy+j/ksize)*iw+(ox+j%ksize)`, where oy=o/ow and ox=o%ow. `acc=1` for j≥1.
- ACC_OUT (1 cycle): `out_valid=1`, `out_idx=o`. Then go to ACC_CLR with o+1, or to DONE after o=len_onij-1.
- DONE (1 cycle): `done=1`, then IDLE.
- Address arithmetic is unsigned at addr_w bits. Elaboration fails if `len_kij*len_nij > w_base` or if `w_base+len_kij*col` exceeds 2^addr_w.

## Timing
- `reset` at any cycle, mid-operation included: next edge gives IDLE, idle instruction, kij=o=t=0, all pulses 0. In-flight memory accesses are abandoned.
- `start` while busy or in DONE is ignored. `start` and `reset` together: reset wins.
- Every `inst` field is a flop output; a field changes one edge after the FSM decision.
- OFIFO stall: while `ofifo_valid=0`, hold n and drive the idle instruction. There is no timeout.
- Latency with `ofifo_valid` held 1, defaults: start to done = 1425 busy cycles. This is 9×137 for the kernel loop plus 16×12 for accumulation.

## Configuration
- `SEQ_PERF_CNT_EN` defined: `cycle_cnt` counts cycles with busy=1, clears on accepted `start` and on `reset`, and holds after done.
- `SEQ_PERF_CNT_EN` undefined: `cycle_cnt` is tied to 0 and no counter flops are built.

## Test plan
- Reset mid-EXEC at kij=4 → next cycle `inst`=0x1_800C_0000, `busy`=0, `core_clr`=0; a fresh `start` runs a full pass.
- Defaults, `ofifo_valid`=1 → exactly 16 `out_valid` pulses with `out_idx` 0..15; `done` after 1425 busy cycles; `cycle_cnt`=1425 with macro, 0 without.
- Monitor xmem addresses → kij=2 W_L0 reads 1040..1047; X_L0 reads 0..35; `l0_wr` high exactly 8 and 36 cycles respectively.
- Monitor pmem addresses in ACC → o=0 reads 0,37,74,...,302; o=5 starts at 7.
- `ofifo_valid` toggling 1,0 in OFIFO → 36 writes at kij*36+0..35, contiguous, no write while valid is 0; loop time grows by 35 cycles per kij.
- `start` pulsed while busy → ignored: no restart and the address sequence is unchanged.
